// File: rtl/axi_lite_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rd_arbiter_if
// Brief    : AXI-lite bus bundle (AR/R/AW/W/B) with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi_lite_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rvalid, awready, wready, bresp, bvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rd_arbiter
// Brief    : IFU (m0) / LSU (m1) read arbiter in front of the AXI-lite RAM;
//            LSU writes pass straight through. Define ARB_FIXED_PRIO_EN for
//            fixed LSU priority instead of round-robin.
// Revision : 1.0
// ============================================================================
module axi_lite_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   axi_lite_rd_arbiter_if.slave  m0,
   axi_lite_rd_arbiter_if.slave  m1,
   axi_lite_rd_arbiter_if.master s,
   output logic                  grant
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_grant;
`ifndef ARB_FIXED_PRIO_EN
   logic              r_last_grant;
`endif
   logic              w_pick;
   logic              w_in_addr;
   logic              w_in_data;
   logic              w_g_arvalid;
   logic [ADDR_W-1:0] w_g_araddr;
   logic [DATA_W-1:0] w_s_rdata;
   logic              w_unused_m0;

   // Requester chosen when leaving IDLE; holds the current owner if nobody asks.
   always_comb begin
      w_pick = r_grant;
      if (m0.arvalid && !m1.arvalid) begin
         w_pick = 1'b0;
      end else if (!m0.arvalid && m1.arvalid) begin
         w_pick = 1'b1;
      end else if (m0.arvalid && m1.arvalid) begin
`ifdef ARB_FIXED_PRIO_EN
         w_pick = 1'b1;
`else
         w_pick = ~r_last_grant;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m0.arvalid || m1.arvalid) begin
                  r_grant <= w_pick;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (w_g_arvalid && s.arready) begin
                  r_state      <= ST_DATA;
`ifndef ARB_FIXED_PRIO_EN
                  r_last_grant <= r_grant;
`endif
               end else if (!w_g_arvalid) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (s.rvalid && s.rready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_in_addr   = (r_state == ST_ADDR);
   assign w_in_data   = (r_state == ST_DATA);
   assign w_g_arvalid = r_grant ? m1.arvalid : m0.arvalid;
   assign w_g_araddr  = r_grant ? m1.araddr  : m0.araddr;
   assign w_s_rdata   = s.rdata;
   assign grant       = r_grant;

   // The RAM only ever sees an address while a read is being granted.
   assign s.araddr    = w_in_addr ? w_g_araddr : '0;
   assign s.arvalid   = w_in_addr & w_g_arvalid;
   assign m0.arready  = w_in_addr & ~r_grant & s.arready;
   assign m1.arready  = w_in_addr &  r_grant & s.arready;

   assign s.rready    = w_in_data & (r_grant ? m1.rready : m0.rready);
   assign m0.rvalid   = w_in_data & ~r_grant & s.rvalid;
   assign m1.rvalid   = w_in_data &  r_grant & s.rvalid;
   assign m0.rdata    = (w_in_data & ~r_grant) ? w_s_rdata : '0;
   assign m1.rdata    = (w_in_data &  r_grant) ? w_s_rdata : '0;

   assign s.awaddr    = m1.awaddr;
   assign s.awvalid   = m1.awvalid;
   assign m1.awready  = s.awready;
   assign s.wdata     = m1.wdata;
   assign s.wstrb     = m1.wstrb;
   assign s.wvalid    = m1.wvalid;
   assign m1.wready   = s.wready;
   assign m1.bresp    = s.bresp;
   assign m1.bvalid   = s.bvalid;
   assign s.bready    = m1.bready;

   // The IFU never writes: its write channel is parked.
   assign m0.awready  = 1'b0;
   assign m0.wready   = 1'b0;
   assign m0.bresp    = 2'b00;
   assign m0.bvalid   = 1'b0;
   assign w_unused_m0 = &{1'b0, m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_rd_arbiter
// Brief    : Scoreboard bench: behavioural RAM, reference memory, directed and
//            random IFU/LSU traffic. Honours ARB_FIXED_PRIO_EN.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_rd_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic grant;
   always #5 clk = ~clk;

   axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
   axi_lite_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

   axi_lite_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .grant (grant)
   );

   logic [31:0] m_araddr [2];
   logic [1:0]  m_arvalid = '0;
   logic [1:0]  m_rready  = '0;
   logic [1:0]  m_arready, m_rvalid;
   logic [31:0] m_rdata [2];

   assign m0_if.araddr  = m_araddr[0];
   assign m0_if.arvalid = m_arvalid[0];
   assign m0_if.rready  = m_rready[0];
   assign m1_if.araddr  = m_araddr[1];
   assign m1_if.arvalid = m_arvalid[1];
   assign m1_if.rready  = m_rready[1];
   assign m0_if.awaddr  = '0;
   assign m0_if.awvalid = 1'b0;
   assign m0_if.wdata   = '0;
   assign m0_if.wstrb   = '0;
   assign m0_if.wvalid  = 1'b0;
   assign m0_if.bready  = 1'b0;
   assign m_arready     = {m1_if.arready, m0_if.arready};
   assign m_rvalid      = {m1_if.rvalid, m0_if.rvalid};
   assign m_rdata[0]    = m0_if.rdata;
   assign m_rdata[1]    = m1_if.rdata;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   logic [1:0]  exp_b  [$];
   logic        grant_log [$];

   logic [31:0] ram [logic [31:0]];
   logic [31:0] mdl [logic [31:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got timeout, expected handshake", nm);
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return mdl.exists(a) ? mdl[a] : dflt(a);
   endfunction

   function automatic logic rnd_ready();
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      ram[a] = d;
      mdl[a] = d;
   endtask

   // Behavioural RAM slave with random ready/response delays.
   initial begin
      logic [31:0] rd_addr, aw_a, w_d, cur;
      logic [3:0]  w_s;
      int          rd_wait;
      bit          rd_busy, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_have, w_have;
      rd_busy = 0; aw_have = 0; w_have = 0; rd_wait = 0;
      rd_addr = '0; aw_a = '0; w_d = '0; w_s = '0;
      s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0;
      s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 2'b00;
      forever begin
         @(negedge clk);
         ar_hs = s_if.arvalid && s_if.arready;
         r_hs  = s_if.rvalid && s_if.rready;
         aw_hs = s_if.awvalid && s_if.awready;
         w_hs  = s_if.wvalid && s_if.wready;
         b_hs  = s_if.bvalid && s_if.bready;
         if (ar_hs) rd_addr = s_if.araddr;
         if (aw_hs) aw_a = s_if.awaddr;
         if (w_hs) begin w_d = s_if.wdata; w_s = s_if.wstrb; end
         @(posedge clk); #1;
         if (rst) begin
            rd_busy = 0; aw_have = 0; w_have = 0;
            s_if.arready = 0; s_if.rvalid = 0; s_if.awready = 0;
            s_if.wready = 0; s_if.bvalid = 0;
         end else begin
            if (ar_hs) begin rd_busy = 1; rd_wait = $urandom_range(0, 2); end
            if (r_hs) begin s_if.rvalid = 0; rd_busy = 0; end
            if (rd_busy && !s_if.rvalid) begin
               if (rd_wait == 0) begin
                  s_if.rvalid = 1;
                  s_if.rdata  = ram.exists(rd_addr) ? ram[rd_addr] : dflt(rd_addr);
               end else begin
                  rd_wait--;
               end
            end
            s_if.arready = !rd_busy && ($urandom_range(0, 2) != 0);
            if (aw_hs) aw_have = 1;
            if (w_hs) w_have = 1;
            if (b_hs) s_if.bvalid = 0;
            if (aw_have && w_have && !s_if.bvalid) begin
               cur = ram.exists(aw_a) ? ram[aw_a] : dflt(aw_a);
               for (int b = 0; b < 4; b++)
                  if (w_s[b]) cur[8*b +: 8] = w_d[8*b +: 8];
               ram[aw_a] = cur;
               s_if.bvalid = 1; s_if.bresp = 2'b00;
               aw_have = 0; w_have = 0;
            end
            s_if.awready = !aw_have && !s_if.bvalid && rnd_ready();
            s_if.wready  = !w_have && !s_if.bvalid && rnd_ready();
         end
      end
   end

   // Monitor: pops expectations on every output handshake, checks invariants.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (m_rvalid[0] && m_rready[0]) begin
               if (exp_q0.size() == 0) chk("m0_unexpected_r", 32'd1, 32'd0);
               else begin e = exp_q0.pop_front(); chk("m0_rdata", m_rdata[0], e); end
               chk("m0_r_grant", {31'b0, grant}, 32'd0);
            end
            if (m_rvalid[1] && m_rready[1]) begin
               if (exp_q1.size() == 0) chk("m1_unexpected_r", 32'd1, 32'd0);
               else begin e = exp_q1.pop_front(); chk("m1_rdata", m_rdata[1], e); end
               chk("m1_r_grant", {31'b0, grant}, 32'd1);
            end
            if (m1_if.bvalid && m1_if.bready) begin
               if (exp_b.size() == 0) chk("m1_unexpected_b", 32'd1, 32'd0);
               else begin e = {30'b0, exp_b.pop_front()}; chk("m1_bresp", {30'b0, m1_if.bresp}, e); end
            end
            if (s_if.arvalid && s_if.arready) grant_log.push_back(grant);
            chk("both_rvalid", {31'b0, m_rvalid[0] & m_rvalid[1]}, 32'd0);
            chk("both_arready", {31'b0, m_arready[0] & m_arready[1]}, 32'd0);
            if (!s_if.arvalid) chk("idle_araddr", s_if.araddr, 32'd0);
            if (m_rvalid[1]) chk("m0_rdata_parked", m_rdata[0], 32'd0);
            if (m_rvalid[0]) chk("m1_rdata_parked", m_rdata[1], 32'd0);
            chk("m0_bvalid", {31'b0, m0_if.bvalid}, 32'd0);
         end
      end
   end

   task automatic do_read(input bit idx, input logic [31:0] addr, input int stall);
      int budget, hold;
      bit done;
      if (idx) exp_q1.push_back(model_rd(addr)); else exp_q0.push_back(model_rd(addr));
      @(posedge clk); #1;
      m_araddr[idx] = addr; m_arvalid[idx] = 1'b1;
      done = 0; budget = 200;
      while (!done && budget > 0) begin
         @(negedge clk);
         done = m_arready[idx];
         budget--;
      end
      @(posedge clk); #1;
      m_arvalid[idx] = 1'b0; m_araddr[idx] = '0;
      if (!done) begin flag("ar_timeout"); return; end
      hold = stall; done = 0; budget = 200;
      m_rready[idx] = (hold > 0) ? 1'b0 : rnd_ready();
      while (!done && budget > 0) begin
         @(negedge clk);
         if (m_rvalid[idx] && m_rready[idx]) done = 1;
         else if (m_rvalid[idx] && hold > 0) hold--;
         budget--;
         @(posedge clk); #1;
         m_rready[idx] = (done || hold > 0) ? 1'b0 : rnd_ready();
      end
      if (!done) flag("r_timeout");
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] cur;
      int budget;
      bit aw_done, w_done, b_done;
      cur = model_rd(addr);
      for (int b = 0; b < 4; b++)
         if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
      mdl[addr] = cur;
      exp_b.push_back(2'b00);
      @(posedge clk); #1;
      m1_if.awaddr = addr; m1_if.awvalid = 1'b1;
      m1_if.wdata = data; m1_if.wstrb = strb; m1_if.wvalid = 1'b1;
      m1_if.bready = 1'b1;
      aw_done = 0; w_done = 0; b_done = 0; budget = 200;
      while (!(aw_done && w_done && b_done) && budget > 0) begin
         @(negedge clk);
         if (m1_if.awvalid && m1_if.awready) aw_done = 1;
         if (m1_if.wvalid && m1_if.wready) w_done = 1;
         if (m1_if.bvalid && m1_if.bready) b_done = 1;
         budget--;
         @(posedge clk); #1;
         if (aw_done) m1_if.awvalid = 1'b0;
         if (w_done) m1_if.wvalid = 1'b0;
      end
      m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0; m1_if.bready = 1'b0;
      if (!b_done) flag("write_timeout");
   endtask

   task automatic apply_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1;
      m_arvalid = '0; m_rready = '0;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
      grant_log.delete();
   endtask

   task automatic check_grants(input string nm, input int n, input logic [7:0] exp);
      chk({nm, "_count"}, grant_log.size(), n);
      for (int i = 0; i < n && i < grant_log.size(); i++)
         chk(nm, {31'b0, grant_log[i]}, {31'b0, exp[i]});
      grant_log.delete();
   endtask

   task automatic check_quiet(input string nm);
      chk({nm, "_s_arvalid"}, {31'b0, s_if.arvalid}, 32'd0);
      chk({nm, "_s_rready"},  {31'b0, s_if.rready}, 32'd0);
      chk({nm, "_m_arready"}, {30'b0, m_arready}, 32'd0);
      chk({nm, "_m_rvalid"},  {30'b0, m_rvalid}, 32'd0);
      chk({nm, "_grant"},     {31'b0, grant}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, expected end of test");
      $fatal(1, "bench stopped by watchdog");
   end

   initial begin
      int budget, blocked;
      bit seen;
      m_araddr[0] = '0; m_araddr[1] = '0;
      m1_if.awaddr = '0; m1_if.awvalid = 1'b0; m1_if.wdata = '0;
      m1_if.wstrb = '0; m1_if.wvalid = 1'b0; m1_if.bready = 1'b0;
      preload(32'h8000_0000, 32'h0000_0413);
      preload(32'h8000_2000, 32'h1234_5678);

      apply_reset(3);
      @(negedge clk);
      check_quiet("reset");

      do_read(1'b0, 32'h8000_0000, 0);
      check_grants("single_ifu", 1, 8'b0);

      apply_reset(2);
      fork
         do_read(1'b0, 32'h8000_0004, 0);
         do_read(1'b1, 32'h8000_1000, 0);
      join
`ifdef ARB_FIXED_PRIO_EN
      check_grants("first_contention", 2, 8'b01);
`else
      check_grants("first_contention", 2, 8'b10);
`endif

      fork
         for (int i = 0; i < 3; i++) do_read(1'b0, 32'h8000_0000 + 32'(4 * i), 0);
         for (int i = 0; i < 3; i++) do_read(1'b1, 32'h8000_1000 + 32'(4 * i), 0);
      join
`ifdef ARB_FIXED_PRIO_EN
      check_grants("held_contention", 6, 8'b000111);
`else
      check_grants("held_contention", 6, 8'b101010);
`endif

      fork
         do_read(1'b0, 32'h8000_0008, 0);
         begin
            repeat (2) @(posedge clk);
            do_write(32'h8000_2000, 32'hDEAD_BEEF, 4'b0011);
         end
      join
      do_read(1'b1, 32'h8000_2000, 0);
      check_grants("store_overlap", 2, 8'b10);

      blocked = 0;
      fork
         do_read(1'b0, 32'h8000_0010, 5);
         begin
            seen = 0; budget = 200;
            while (!seen && budget > 0) begin
               @(negedge clk);
               seen = m_arvalid[0] && m_arready[0];
               budget--;
            end
            if (!seen) flag("stall_wait");
            do_read(1'b1, 32'h8000_1004, 0);
         end
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (m_arvalid[1] && m_rvalid[0] && !m_rready[0]) begin
               blocked++;
               chk("stall_m1_arready", {31'b0, m_arready[1]}, 32'd0);
            end
         end
      join
      chk("stall_blocked_cycles", {31'b0, blocked >= 5}, 32'd1);
      check_grants("stall", 2, 8'b10);

      @(posedge clk); #1;
      m_araddr[0] = 32'h8000_0014; m_arvalid[0] = 1'b1;
      seen = 0; budget = 200;
      while (!seen && budget > 0) begin
         @(negedge clk); seen = m_arready[0]; budget--;
      end
      @(posedge clk); #1;
      m_arvalid[0] = 1'b0; m_araddr[0] = '0;
      if (!seen) flag("rst_ar_wait");
      seen = 0; budget = 200;
      while (!seen && budget > 0) begin
         @(negedge clk); seen = m_rvalid[0]; budget--;
      end
      if (!seen) flag("rst_r_wait");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_quiet("rst_in_data");
      @(posedge clk); #1;
      rst = 1'b0;
      grant_log.delete();
      fork
         do_read(1'b0, 32'h8000_0018, 0);
         do_read(1'b1, 32'h8000_1008, 0);
      join
`ifdef ARB_FIXED_PRIO_EN
      check_grants("after_reset", 2, 8'b01);
`else
      check_grants("after_reset", 2, 8'b10);
`endif

      fork
         for (int i = 0; i < 20; i++)
            do_read(1'b0, 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)), $urandom_range(0, 2));
         for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) != 0)
               do_write(32'h8000_3000 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15)));
            else
               do_read(1'b1, 32'h8000_3000 + 32'(4 * $urandom_range(0, 7)), $urandom_range(0, 2));
         end
      join
      grant_log.delete();

      repeat (4) @(negedge clk);
      chk("m0_queue_drained", exp_q0.size(), 0);
      chk("m1_queue_drained", exp_q1.size(), 0);
      chk("b_queue_drained", exp_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master to one-slave arbiter for the read channels of the unified AXI-lite RAM.
- Master 0 is the IFU (instruction fetch, read-only). Master 1 is the LSU (loads and stores).
- Read transactions (AR + R) are arbitrated and locked per transaction. The LSU write channels (AW/W/B) pass straight through to the RAM.
- Sits between the core front/back end and the RAM slave in the sim top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_araddr / m0_arvalid / m0_arready  in / in / out  ADDR_W/1/1  IFU read-address channel
- m0_rdata / m0_rvalid / m0_rready  out / out / in  DATA_W/1/1  IFU read-data channel
- m1_araddr / m1_arvalid / m1_arready  in / in / out  ADDR_W/1/1  LSU read-address channel
- m1_rdata / m1_rvalid / m1_rready  out / out / in  DATA_W/1/1  LSU read-data channel
- m1_awaddr / m1_awvalid / m1_awready  in / in / out  ADDR_W/1/1  LSU write address
- m1_wdata / m1_wstrb / m1_wvalid / m1_wready  in / in / in / out  DATA_W/4/1/1  LSU write data
- m1_bresp / m1_bvalid / m1_bready  out / out / in  2/1/1  LSU write response
- s_araddr / s_arvalid / s_arready  out / out / in  ADDR_W/1/1  to RAM
- s_rdata / s_rvalid / s_rready  in / in / out  DATA_W/1/1  from RAM
- s_aw*, s_w*, s_b*  mirror m1_aw*/m1_w*/m1_b* with opposite directions, same widths
- grant  out  1  0 = IFU owns read path, 1 = LSU owns read path (debug/trace)

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: state, grant, last_grant.
- Reset: state=IDLE, grant=0, last_grant=1 (IFU wins first contention).
- Reset values of control outputs: s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0. Reset mid-transaction drops to IDLE the same edge; the RAM is reset by the same rst.
- IDLE:
  - If no m*_arvalid, stay in IDLE.
  - If exactly one requester, grant it.
  - If both request, grant !last_grant (round-robin).
  - On grant: go to ADDR.
- ADDR:
  - s_araddr = granted m_araddr; s_arvalid = granted m_arvalid.
  - granted m_arready = s_arready; the non-granted m_arready = 0.
  - On s_arvalid & s_arready: go to DATA, last_grant <= grant.
  - If the granted master drops arvalid before handshake (protocol violation), return to IDLE.
- DATA:
  - granted m_rvalid = s_rvalid; granted m_rdata = s_rdata; s_rready = granted m_rready.
  - Non-granted m_rvalid = 0.
  - On s_rvalid & s_rready: go to IDLE.
- Latency: a request seen in IDLE reaches s_arvalid one cycle later. Back-to-back reads cost 1 idle cycle between transactions.
- Outside ADDR: s_araddr = 0 and s_arvalid = 0, so the RAM never latches a stale address.
- Write path: pure combinational pass-through m1 <-> s. It is never stalled by read arbitration; reads and writes may overlap.
- Simultaneous new request during DATA: held off until IDLE; the requester sees arready=0.
- rdata to the non-granted master: drive 0.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, LSU (m1) always wins contention in IDLE; last_grant is unused.
- Undefined: round-robin as above.
- Both builds share the same ports and latency.

Test Plan:
- Single IFU read of 0x80000000, RAM returns 0x00000413 -> m0_rvalid with rdata=0x00000413; grant stays 0; m1_rvalid stays 0.
- Both arvalid in the same cycle after reset (m0=0x80000004, m1=0x80001000) -> IFU served first, then LSU. With ARB_FIXED_PRIO_EN -> LSU served first.
- Both masters hold arvalid for 6 transactions -> grants alternate 0,1,0,1,0,1. Each master's rdata matches the RAM contents at its own address.
- LSU store 0xDEADBEEF, wstrb=4'b0011, to 0x80002000 during an in-flight IFU read -> bvalid with bresp=OK; IFU read unaffected. A later LSU read returns 0x????BEEF with the upper half unchanged.
- m0_rready held low 5 cycles while s_rvalid=1 -> stays in DATA, m1 request blocked (m1_arready=0) until m0_rready=1.
- rst asserted while in DATA -> next cycle state=IDLE, all valids/readies 0, grant=0; the first request after reset completes normally.
